// File: rtl/seg7_mux_driver.sv
// Time-multiplexed 7-segment driver: scans DIGITS digits with an anti-ghost guard,
// per-digit decimal point, leading-zero blanking and frame-synchronous value updates.
module seg7_mux_driver #(
  parameter int DIGITS     = 4,
  parameter int DIV_BITS   = 16,
  parameter int GUARD      = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg,
  output logic                  frame_tick
);

  localparam int                  IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_BITS-1:0] PRESC_MAX    = '1;
  localparam logic [DIV_BITS-1:0] GUARD_CYCLES = DIV_BITS'(GUARD);
  localparam logic [IDX_W-1:0]    LAST_DIGIT   = IDX_W'(DIGITS - 1);

  typedef struct packed {
    logic [DIGITS-1:0][3:0] nib;
    logic [DIGITS-1:0]      dp;
  } frame_t;

  logic [DIV_BITS-1:0] presc;
  logic [IDX_W-1:0]    digit_idx;
  frame_t              pending;
  frame_t              display;
  logic                pending_valid;

  logic                slot_end;
  logic                frame_wrap;
  logic [DIGITS-1:0]   upper_zero;
  logic                blank_digit;
  logic [DIGITS-1:0]   sel_next;
  logic [7:0]          seg_next;

  // Active-high segment pattern, a = bit 0.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  assign slot_end   = (presc == PRESC_MAX);
  assign frame_wrap = slot_end && (digit_idx == LAST_DIGIT);

  // upper_zero[i]: nibbles i..DIGITS-1 of the shown value are all zero.
  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    upper_zero             = '0;
    upper_zero[DIGITS-1]   = (display.nib[DIGITS-1] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (display.nib[i] == 4'h0);
    end
  end

  always_comb begin
    blank_digit = blank_lz && (digit_idx != '0) && upper_zero[digit_idx];
    seg_next    = {display.dp[digit_idx],
                   blank_digit ? 7'h00 : hex_to_seg(display.nib[digit_idx])};
    sel_next    = (presc < GUARD_CYCLES) ? '0 : (DIGITS'(1) << digit_idx);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc         <= '0;
      digit_idx     <= '0;
      pending       <= '0;
      display       <= '0;
      pending_valid <= 1'b0;
      sel           <= ACTIVE_LOW ? '1 : '0;
      seg           <= ACTIVE_LOW ? 8'hFF : 8'h00;
      frame_tick    <= 1'b0;
    end else begin
      presc <= presc + 1'b1;
      if (slot_end) begin
        digit_idx <= frame_wrap ? '0 : digit_idx + 1'b1;
      end

      // A load landing on the wrap cycle bypasses pending and is shown this frame.
      if (frame_wrap) begin
        pending_valid <= 1'b0;
        if (load) begin
          display <= '{nib: value, dp: dp};
        end else if (pending_valid) begin
          display <= pending;
        end
      end else if (load) begin
        pending       <= '{nib: value, dp: dp};
        pending_valid <= 1'b1;
      end

      frame_tick <= frame_wrap;
      sel        <= ACTIVE_LOW ? ~sel_next : sel_next;
      seg        <= ACTIVE_LOW ? ~seg_next : seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver: an active-low instance (DIV_BITS=3, GUARD=2)
// and an active-high instance, sharing clock and reset, checked at bench-tracked cycles.
module tb_seg7_mux_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_a, value_b;
  logic [3:0]  dp_a, dp_b, sel_a, sel_b;
  logic        load_a, load_b, blank_a, blank_b;
  logic [7:0]  seg_a, seg_b;
  logic        tick_a, tick_b;

  // Edges seen since the last reset release; state index shown after edge n is n-1.
  int cyc;
  int n_checks;
  int n_fail;

  always #5 clk = ~clk;

  seg7_mux_driver #(.DIGITS(4), .DIV_BITS(3), .GUARD(2), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .value(value_a), .dp(dp_a), .load(load_a),
    .blank_lz(blank_a), .sel(sel_a), .seg(seg_a), .frame_tick(tick_a)
  );

  seg7_mux_driver #(.DIGITS(4), .DIV_BITS(3), .GUARD(2), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .value(value_b), .dp(dp_b), .load(load_b),
    .blank_lz(blank_b), .sel(sel_b), .seg(seg_b), .frame_tick(tick_b)
  );

  task automatic tick();
    @(posedge clk);
    cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic go_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic test_reset();
    n_checks++; if (sel_a !== 4'hF)  begin n_fail++; $display("FAIL reset_sel_a: got %h expected F", sel_a); end
    n_checks++; if (seg_a !== 8'hFF) begin n_fail++; $display("FAIL reset_seg_a: got %h expected FF", seg_a); end
    n_checks++; if (tick_a !== 1'b0) begin n_fail++; $display("FAIL reset_tick_a: got %b expected 0", tick_a); end
    n_checks++; if (sel_b !== 4'h0)  begin n_fail++; $display("FAIL reset_sel_b: got %h expected 0", sel_b); end
    n_checks++; if (seg_b !== 8'h00) begin n_fail++; $display("FAIL reset_seg_b: got %h expected 00", seg_b); end
    rst = 1'b0;
    cyc = 0;
    go_to(20);
    n_checks++; if (sel_a !== 4'hB)  begin n_fail++; $display("FAIL prereset_sel_digit2: got %h expected B", sel_a); end
    rst = 1'b1;
    #1;
    n_checks++; if (sel_a !== 4'hF)  begin n_fail++; $display("FAIL midscan_reset_sel: got %h expected F", sel_a); end
    n_checks++; if (seg_a !== 8'hFF) begin n_fail++; $display("FAIL midscan_reset_seg: got %h expected FF", seg_a); end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    tick();
    n_checks++; if (sel_a !== 4'hF)  begin n_fail++; $display("FAIL release_guard0_sel: got %h expected F", sel_a); end
    tick();
    n_checks++; if (sel_a !== 4'hF)  begin n_fail++; $display("FAIL release_guard1_sel: got %h expected F", sel_a); end
    tick();
    n_checks++; if (sel_a !== 4'hE)  begin n_fail++; $display("FAIL release_first_digit_sel: got %h expected E", sel_a); end
    n_checks++; if (seg_a !== 8'hC0) begin n_fail++; $display("FAIL release_first_digit_seg: got %h expected C0", seg_a); end
  endtask

  task automatic test_scan();
    logic [3:0] es [4];
    logic [7:0] eg [4];
    es = '{4'hE, 4'hD, 4'hB, 4'h7};
    eg = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
    value_a = 16'h12AF; dp_a = 4'h0; load_a = 1'b1; load_b = 1'b1;
    tick();
    load_a = 1'b0; load_b = 1'b0;
    go_to(27);
    n_checks++; if (seg_a !== 8'hC0) begin n_fail++; $display("FAIL pre_wrap_old_value: got %h expected C0", seg_a); end
    n_checks++; if (sel_a !== 4'h7)  begin n_fail++; $display("FAIL pre_wrap_digit3_sel: got %h expected 7", sel_a); end
    go_to(31);
    n_checks++; if (tick_a !== 1'b0) begin n_fail++; $display("FAIL tick_before_wrap: got %b expected 0", tick_a); end
    tick();
    n_checks++; if (tick_a !== 1'b1) begin n_fail++; $display("FAIL tick_after_wrap: got %b expected 1", tick_a); end
    tick();
    n_checks++; if (tick_a !== 1'b0) begin n_fail++; $display("FAIL tick_one_cycle: got %b expected 0", tick_a); end
    n_checks++; if (seg_a !== 8'h8E) begin n_fail++; $display("FAIL guard_seg_shown: got %h expected 8E", seg_a); end
    for (int d = 0; d < 4; d++) begin
      go_to(32 + 8*d + 2);
      n_checks++; if (sel_a !== 4'hF) begin n_fail++; $display("FAIL scan_guard_d%0d: got %h expected F", d, sel_a); end
      tick();
      n_checks++; if (sel_a !== es[d]) begin n_fail++; $display("FAIL scan_sel_d%0d: got %h expected %h", d, sel_a, es[d]); end
      n_checks++; if (seg_a !== eg[d]) begin n_fail++; $display("FAIL scan_seg_d%0d: got %h expected %h", d, seg_a, eg[d]); end
      go_to(32 + 8*d + 8);
      n_checks++; if (sel_a !== es[d]) begin n_fail++; $display("FAIL scan_slot_end_d%0d: got %h expected %h", d, sel_a, es[d]); end
    end
  endtask

  task automatic test_blank();
    logic [7:0] eg [4];
    eg = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
    value_a = 16'h0050; load_a = 1'b1; blank_a = 1'b1;
    tick();
    load_a = 1'b0;
    for (int d = 0; d < 4; d++) begin
      go_to(96 + 8*d + 3);
      n_checks++; if (seg_a !== eg[d]) begin n_fail++; $display("FAIL blank_seg_d%0d: got %h expected %h", d, seg_a, eg[d]); end
    end
    blank_a = 1'b0;
    go_to(147);
    n_checks++; if (seg_a !== 8'hC0) begin n_fail++; $display("FAIL noblank_seg_d2: got %h expected C0", seg_a); end
    go_to(155);
    n_checks++; if (seg_a !== 8'hC0) begin n_fail++; $display("FAIL noblank_seg_d3: got %h expected C0", seg_a); end
  endtask

  task automatic test_back_to_back();
    go_to(162);
    value_a = 16'h1111; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    go_to(170);
    value_a = 16'h2222; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    n_checks++; if (seg_a !== 8'h92) begin n_fail++; $display("FAIL no_tear_d1: got %h expected 92", seg_a); end
    go_to(179);
    n_checks++; if (seg_a !== 8'hC0) begin n_fail++; $display("FAIL no_tear_d2: got %h expected C0", seg_a); end
    for (int d = 0; d < 4; d++) begin
      go_to(192 + 8*d + 3);
      n_checks++; if (seg_a !== 8'hA4) begin n_fail++; $display("FAIL last_load_d%0d: got %h expected A4", d, seg_a); end
    end
  endtask

  task automatic test_load_on_wrap();
    go_to(223);
    value_a = 16'h0007; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    n_checks++; if (tick_a !== 1'b1) begin n_fail++; $display("FAIL wrap_load_tick: got %b expected 1", tick_a); end
    go_to(227);
    n_checks++; if (seg_a !== 8'hF8) begin n_fail++; $display("FAIL wrap_load_d0: got %h expected F8", seg_a); end
    go_to(235);
    n_checks++; if (seg_a !== 8'hC0) begin n_fail++; $display("FAIL wrap_load_d1: got %h expected C0", seg_a); end
    go_to(251);
    n_checks++; if (seg_a !== 8'hC0) begin n_fail++; $display("FAIL wrap_load_d3: got %h expected C0", seg_a); end
    go_to(256);
    n_checks++; if (tick_a !== 1'b1) begin n_fail++; $display("FAIL next_wrap_tick: got %b expected 1", tick_a); end
    go_to(259);
    n_checks++; if (seg_a !== 8'hF8) begin n_fail++; $display("FAIL next_wrap_d0: got %h expected F8", seg_a); end
    go_to(275);
    n_checks++; if (seg_a !== 8'hC0) begin n_fail++; $display("FAIL next_wrap_d2: got %h expected C0", seg_a); end
  endtask

  task automatic test_active_high();
    logic [3:0] es [4];
    logic [7:0] eg [4];
    es = '{4'h1, 4'h2, 4'h4, 4'h8};
    eg = '{8'h3F, 8'h00, 8'h80, 8'h00};
    for (int d = 0; d < 4; d++) begin
      go_to(288 + 8*d + 2);
      n_checks++; if (sel_b !== 4'h0) begin n_fail++; $display("FAIL ah_guard_d%0d: got %h expected 0", d, sel_b); end
      tick();
      n_checks++; if (sel_b !== es[d]) begin n_fail++; $display("FAIL ah_sel_d%0d: got %h expected %h", d, sel_b, es[d]); end
      n_checks++; if (seg_b !== eg[d]) begin n_fail++; $display("FAIL ah_seg_d%0d: got %h expected %h", d, seg_b, eg[d]); end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    value_a = '0; dp_a = '0; load_a = 1'b0; blank_a = 1'b0;
    value_b = 16'h0000; dp_b = 4'b0100; load_b = 1'b0; blank_b = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_scan();
    test_blank();
    test_back_to_back();
    test_load_on_wrap();
    test_active_high();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
